// File: rtl/vote_session_ctrl_pkg.sv
// Shared types and constants for the voting session controller.
package vote_pkg;

    localparam int VOTERS    = 4;
    localparam int CHAIR_IDX = 0;
    localparam int CNT_W     = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OPEN  = 2'd1,
        TALLY = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/vote_session_ctrl_if.sv
// Session control / ballot bus between a chair console (master) and the controller (slave).
interface vote_session_ctrl_if;
    import vote_pkg::*;

    logic              start;
    logic              abort;
    logic [VOTERS-1:0] vote_stb;
    logic [VOTERS-1:0] vote_val;
    logic              busy;
    logic [VOTERS-1:0] voted;
    logic [2:0]        yes_cnt;
    logic              result;
    logic              result_valid;

    modport master (
        output start, abort, vote_stb, vote_val,
        input  busy, voted, yes_cnt, result, result_valid
    );

    modport slave (
        input  start, abort, vote_stb, vote_val,
        output busy, voted, yes_cnt, result, result_valid
    );
endinterface

// File: rtl/vote_session_ctrl_tally.sv
// Combinational tally: counts locked yes ballots and applies the chairman tie-break.
module vote_tally
    import vote_pkg::*;
(
    input  logic [VOTERS-1:0] i_ballot,
    input  logic [VOTERS-1:0] i_voted,
    output logic [2:0]        o_yes_cnt,
    output logic              o_result
);
    logic [VOTERS-1:0] w_yes;
    logic [2:0]        w_cnt;

    // Abstainers carry no locked ballot, so masking with voted makes them "no".
    always_comb begin
        w_yes = i_ballot & i_voted;
        w_cnt = 3'd0;
        for (int i = 0; i < VOTERS; i++) begin
            w_cnt = w_cnt + 3'(w_yes[i]);
        end
    end

    assign o_yes_cnt = w_cnt;
    assign o_result  = (w_cnt >= 3'd3) || ((w_cnt == 3'd2) && w_yes[CHAIR_IDX]);
endmodule

// File: rtl/vote_session_ctrl.sv
// Voting session FSM: opens a timed window, locks first ballots, tallies once, holds the result.
module vote_session_ctrl #(
    parameter int WINDOW_CYCLES = 1000,
    parameter int VOTERS        = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    vote_session_ctrl_if.slave   bus
);
    localparam logic [vote_pkg::CNT_W-1:0] CNT_LOAD  = vote_pkg::CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [VOTERS-1:0]          ALL_VOTED = '1;

    vote_pkg::state_t             r_state;
    logic [vote_pkg::CNT_W-1:0]   r_cnt;
    logic [VOTERS-1:0]            r_ballot;
    logic [VOTERS-1:0]            r_voted;
    logic [2:0]                   r_yes_cnt;
    logic                         r_result;
    logic                         r_result_valid;

    logic [VOTERS-1:0]            w_new;
    logic [2:0]                   w_yes_cnt;
    logic                         w_result;
    logic                         w_busy;

    assign w_new  = bus.vote_stb & ~r_voted;
    assign w_busy = (r_state == vote_pkg::OPEN) || (r_state == vote_pkg::TALLY);

    vote_tally u_tally (
        .i_ballot  (r_ballot),
        .i_voted   (r_voted),
        .o_yes_cnt (w_yes_cnt),
        .o_result  (w_result)
    );

    always_ff @(posedge clk) begin
        if (rst || (bus.abort && w_busy)) begin
            r_state        <= vote_pkg::IDLE;
            r_cnt          <= '0;
            r_ballot       <= '0;
            r_voted        <= '0;
            r_yes_cnt      <= '0;
            r_result       <= 1'b0;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            case (r_state)
                // abort outranks start even where abort itself does nothing
                vote_pkg::IDLE, vote_pkg::DONE: begin
                    if (bus.start && !bus.abort) begin
                        r_state   <= vote_pkg::OPEN;
                        r_cnt     <= CNT_LOAD;
                        r_ballot  <= '0;
                        r_voted   <= '0;
                        r_yes_cnt <= '0;
                        r_result  <= 1'b0;
                    end
                end
                vote_pkg::OPEN: begin
                    r_ballot <= (r_ballot & ~w_new) | (bus.vote_val & w_new);
                    r_voted  <= r_voted | w_new;
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                    if ((r_cnt == '0) || (r_voted == ALL_VOTED)) begin
                        r_state <= vote_pkg::TALLY;
                    end
                end
                vote_pkg::TALLY: begin
                    r_yes_cnt      <= w_yes_cnt;
                    r_result       <= w_result;
                    r_result_valid <= 1'b1;
                    r_state        <= vote_pkg::DONE;
                end
            endcase
        end
    end

    assign bus.busy         = w_busy;
    assign bus.voted        = r_voted;
    assign bus.yes_cnt      = r_yes_cnt;
    assign bus.result       = r_result;
    assign bus.result_valid = r_result_valid;
endmodule

// File: tb/tb_vote_session_ctrl.sv
// Directed table-driven bench for vote_session_ctrl with a 16-cycle window.
module tb_vote_session_ctrl;

    typedef struct {
        logic       rst;
        logic       start;
        logic       abort;
        logic [3:0] stb;
        logic [3:0] val;
        logic       busy;
        logic [3:0] voted;
        logic [2:0] yes;
        logic       res;
        logic       rv;
    } vec_t;

    logic clk;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;
    vec_t vecs[$];

    vote_session_ctrl_if bus ();

    vote_session_ctrl #(.WINDOW_CYCLES(16), .VOTERS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic v(input logic r, input logic s, input logic a, input logic [3:0] stb,
                     input logic [3:0] val, input logic b, input logic [3:0] vd,
                     input logic [2:0] y, input logic res, input logic rv);
        vec_t t;
        t.rst = r; t.start = s; t.abort = a; t.stb = stb; t.val = val;
        t.busy = b; t.voted = vd; t.yes = y; t.res = res; t.rv = rv;
        vecs.push_back(t);
    endtask

    task automatic drive(input logic r, input logic s, input logic a,
                         input logic [3:0] stb, input logic [3:0] val);
        rst = r; bus.start = s; bus.abort = a; bus.vote_stb = stb; bus.vote_val = val;
    endtask

    task automatic chk_all(input string tag, input int idx, input logic b, input logic [3:0] vd,
                           input logic [2:0] y, input logic res, input logic rv);
        chk({tag, ".busy"},  idx, 8'(bus.busy),         8'(b));
        chk({tag, ".voted"}, idx, 8'(bus.voted),        8'(vd));
        chk({tag, ".yes"},   idx, 8'(bus.yes_cnt),      8'(y));
        chk({tag, ".res"},   idx, 8'(bus.result),       8'(res));
        chk({tag, ".rv"},    idx, 8'(bus.result_valid), 8'(rv));
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);

        //  rst st ab  stb    val     busy voted  yes  res rv
        v(1, 0, 0, 4'h0, 4'h0,  0, 4'h0, 3'd0, 0, 0);  // reset state
        // three yes, chairman no, all strobed together
        v(0, 1, 0, 4'h0, 4'h0,  1, 4'h0, 3'd0, 0, 0);
        v(0, 0, 0, 4'hF, 4'hE,  1, 4'hF, 3'd0, 0, 0);
        v(0, 0, 0, 4'h0, 4'h0,  1, 4'hF, 3'd0, 0, 0);
        v(0, 0, 0, 4'h0, 4'h0,  0, 4'hF, 3'd3, 1, 1);
        v(0, 0, 0, 4'hF, 4'h0,  0, 4'hF, 3'd3, 1, 0);  // strobes in DONE ignored
        v(0, 0, 1, 4'h0, 4'h0,  0, 4'hF, 3'd3, 1, 0);  // abort in DONE ignored
        // tie with chairman yes
        v(0, 1, 0, 4'h0, 4'h0,  1, 4'h0, 3'd0, 0, 0);
        v(0, 0, 0, 4'hF, 4'h3,  1, 4'hF, 3'd0, 0, 0);
        v(0, 0, 0, 4'h0, 4'h0,  1, 4'hF, 3'd0, 0, 0);
        v(0, 0, 0, 4'h0, 4'h0,  0, 4'hF, 3'd2, 1, 1);
        // tie with chairman no
        v(0, 1, 0, 4'h0, 4'h0,  1, 4'h0, 3'd0, 0, 0);
        v(0, 0, 0, 4'hF, 4'hC,  1, 4'hF, 3'd0, 0, 0);
        v(0, 0, 0, 4'h0, 4'h0,  1, 4'hF, 3'd0, 0, 0);
        v(0, 0, 0, 4'h0, 4'h0,  0, 4'hF, 3'd2, 0, 1);
        // double vote: voter 3 yes then no; start mid-session ignored
        v(0, 1, 0, 4'h0, 4'h0,  1, 4'h0, 3'd0, 0, 0);
        v(0, 0, 0, 4'h8, 4'h8,  1, 4'h8, 3'd0, 0, 0);
        v(0, 0, 0, 4'h8, 4'h0,  1, 4'h8, 3'd0, 0, 0);
        v(0, 1, 0, 4'h0, 4'h0,  1, 4'h8, 3'd0, 0, 0);
        v(0, 0, 0, 4'h7, 4'h0,  1, 4'hF, 3'd0, 0, 0);
        v(0, 0, 0, 4'h0, 4'h0,  1, 4'hF, 3'd0, 0, 0);
        v(0, 0, 0, 4'h0, 4'h0,  0, 4'hF, 3'd1, 0, 1);
        // abort on OPEN cycle 5
        v(0, 1, 0, 4'h0, 4'h0,  1, 4'h0, 3'd0, 0, 0);
        v(0, 0, 0, 4'h1, 4'h1,  1, 4'h1, 3'd0, 0, 0);
        v(0, 0, 0, 4'h0, 4'h0,  1, 4'h1, 3'd0, 0, 0);
        v(0, 0, 0, 4'h0, 4'h0,  1, 4'h1, 3'd0, 0, 0);
        v(0, 0, 0, 4'h0, 4'h0,  1, 4'h1, 3'd0, 0, 0);
        v(0, 0, 1, 4'h0, 4'h0,  0, 4'h0, 3'd0, 0, 0);
        v(0, 0, 0, 4'h0, 4'h0,  0, 4'h0, 3'd0, 0, 0);
        v(0, 1, 1, 4'h0, 4'h0,  0, 4'h0, 3'd0, 0, 0);  // start+abort from IDLE
        v(0, 0, 0, 4'hF, 4'hF,  0, 4'h0, 3'd0, 0, 0);  // strobes in IDLE ignored
        // reset during TALLY, then a normal session
        v(0, 1, 0, 4'h0, 4'h0,  1, 4'h0, 3'd0, 0, 0);
        v(0, 0, 0, 4'hF, 4'hF,  1, 4'hF, 3'd0, 0, 0);
        v(0, 0, 0, 4'h0, 4'h0,  1, 4'hF, 3'd0, 0, 0);
        v(1, 1, 0, 4'hF, 4'hF,  0, 4'h0, 3'd0, 0, 0);
        v(0, 1, 0, 4'h0, 4'h0,  1, 4'h0, 3'd0, 0, 0);
        v(0, 0, 0, 4'hF, 4'h5,  1, 4'hF, 3'd0, 0, 0);
        v(0, 0, 0, 4'h0, 4'h0,  1, 4'hF, 3'd0, 0, 0);
        v(0, 0, 0, 4'h0, 4'h0,  0, 4'hF, 3'd2, 1, 1);
        // abort during TALLY: no late result pulse
        v(0, 1, 0, 4'h0, 4'h0,  1, 4'h0, 3'd0, 0, 0);
        v(0, 0, 0, 4'hF, 4'hF,  1, 4'hF, 3'd0, 0, 0);
        v(0, 0, 0, 4'h0, 4'h0,  1, 4'hF, 3'd0, 0, 0);
        v(0, 0, 1, 4'h0, 4'h0,  0, 4'h0, 3'd0, 0, 0);
        v(0, 0, 0, 4'h0, 4'h0,  0, 4'h0, 3'd0, 0, 0);

        step();
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].start, vecs[i].abort, vecs[i].stb, vecs[i].val);
            step();
            chk_all("vec", i, vecs[i].busy, vecs[i].voted, vecs[i].yes, vecs[i].res, vecs[i].rv);
        end

        // timeout: voter 2 on OPEN cycle 3, voter 1 on the 16th (last) OPEN cycle
        drive(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
        step();
        for (int k = 1; k <= 16; k++) begin
            if (k == 3)       drive(1'b0, 1'b0, 1'b0, 4'h4, 4'h4);
            else if (k == 16) drive(1'b0, 1'b0, 1'b0, 4'h2, 4'h2);
            else              drive(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
            step();
            chk("tmo.busy", k, 8'(bus.busy), 8'd1);
            chk("tmo.rv",   k, 8'(bus.result_valid), 8'd0);
        end
        chk("tmo.voted_tally", 17, 8'(bus.voted), 8'h6);
        drive(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
        step();
        chk_all("tmo.done", 18, 1'b0, 4'h6, 3'd2, 1'b0, 1'b1);
        step();
        chk_all("tmo.hold", 19, 1'b0, 4'h6, 3'd2, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vote_session_ctrl.md
VOTE_SESSION_CTRL -- requirements
Module: vote_session_ctrl

Interface
REQ-001 SHALL have parameter WINDOW_CYCLES, default 1000: voting-window length in clk cycles, legal range 2..65535.
REQ-002 SHALL have parameter VOTERS, default 4: number of voters, fixed at 4 for this revision.
REQ-003 SHALL have port clk  input  1  single clock; all logic is rising-edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to open a voting session.
REQ-006 SHALL have port abort  input  1  one-cycle request to cancel the current session.
REQ-007 SHALL have port vote_stb  input  4  per-voter vote strobe; bit 0 is the chairman.
REQ-008 SHALL have port vote_val  input  4  per-voter ballot, 1 = yes, sampled with vote_stb.
REQ-009 SHALL have port busy  output  1  high while in state OPEN or TALLY.
REQ-010 SHALL have port voted  output  4  mask of voters whose ballot is locked.
REQ-011 SHALL have port yes_cnt  output  3  count of yes ballots, 0..4.
REQ-012 SHALL have port result  output  1  1 = motion passed; valid when in DONE.
REQ-013 SHALL have port result_valid  output  1  one-cycle pulse on the first DONE cycle.

Function
REQ-014 SHALL implement FSM states IDLE, OPEN, TALLY and DONE.
REQ-015 IDLE or DONE with start=1 SHALL go to OPEN next cycle, clearing voted, ballots, yes_cnt and result, and loading the window counter with WINDOW_CYCLES-1.
REQ-016 In OPEN, vote_stb[i]=1 with voted[i]=0 SHALL lock vote_val[i] and set voted[i] next cycle.
REQ-017 Later strobes from an already-locked voter SHALL be ignored (first ballot wins).
REQ-018 In OPEN, the window counter SHALL decrement once per cycle.
REQ-019 OPEN SHALL exit to TALLY after the cycle in which the counter equals 0.
REQ-020 OPEN SHALL also exit to TALLY on the cycle after all 4 voted bits are set.
REQ-021 A strobe arriving on the final OPEN cycle (counter=0) SHALL be counted.
REQ-022 TALLY SHALL last exactly 1 cycle, compute yes_cnt and result, then go to DONE.
REQ-023 Voters that did not vote SHALL count as no (abstention = no).
REQ-024 result SHALL be 1 if yes_cnt>=3, or if yes_cnt==2 and the chairman (bit 0) voted yes; otherwise result SHALL be 0.
REQ-025 result_valid SHALL pulse for exactly 1 cycle, on the first DONE cycle.
REQ-026 DONE SHALL hold voted, yes_cnt and result stable until the next start.
REQ-027 start SHALL be ignored in OPEN and in TALLY.
REQ-028 vote_stb SHALL be ignored outside OPEN.
REQ-029 abort in OPEN or TALLY SHALL go to IDLE next cycle, clear all outputs, and produce no result_valid pulse.
REQ-030 abort in IDLE or DONE SHALL have no effect.
REQ-031 If start and abort are both high in the same cycle, abort SHALL take priority over start.
REQ-032 Latency from the last vote (all 4 voted) to result_valid SHALL be 3 cycles: lock, TALLY, DONE.

Reset
REQ-033 rst=1 at a clock edge SHALL force state IDLE from any state, including mid-session.
REQ-034 Reset SHALL set busy=0, voted=0, yes_cnt=0, result=0, result_valid=0 and the window counter to 0.
REQ-035 rst SHALL take priority over start, abort and vote_stb.

Structure
REQ-036 Package vote_pkg SHALL hold the state encoding (IDLE=0, OPEN=1, TALLY=2, DONE=3) and the constants VOTERS=4 and CHAIR_IDX=0.
REQ-037 Sub-module vote_tally SHALL be purely combinational: ballots + voted mask in, yes_cnt + decision out, registered in TALLY.
REQ-038 The window counter width SHALL be 16 bits.
REQ-039 Only the FSM, the counter, the ballot registers and the output registers SHALL be sequential.

Verification (WINDOW_CYCLES=16)
REQ-040 Scenario: start; voters 1, 2, 3 yes; voter 0 no; all four strobed on the same cycle -> result_valid exactly 3 cycles later, yes_cnt=3, result=1.
REQ-041 Scenario: tie break; voter 0 yes, voter 1 yes, voters 2 and 3 no -> yes_cnt=2, result=1; repeat with voters 0 and 1 no, voters 2 and 3 yes -> result=0.
REQ-042 Scenario: timeout; only voter 2 votes yes; vote_stb from voter 1 lands on the 16th OPEN cycle -> both ballots counted, voted=4'b0110, result_valid 2 cycles after window end.
REQ-043 Scenario: double vote; voter 3 strobes yes then no -> voter 3 counted as yes; mid-session start ignored, busy stays 1.
REQ-044 Scenario: abort on OPEN cycle 5 -> IDLE next cycle, all outputs 0, no result_valid pulse; start+abort in the same cycle from IDLE -> stays IDLE.
REQ-045 Scenario: rst asserted during TALLY -> IDLE with all outputs 0 next cycle; a fresh start then runs a normal session.
